// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the byte-stream memory loader.
//   loader_state_t  - FSM state encoding for mem_loader
//   BYTES_PER_WORD  - stream bytes that make up one 20-bit memory word
//   LEN_WIDTH       - width of the little-endian word-count header
package mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD = 3;
  localparam int LEN_WIDTH      = 16;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: collects three stream bytes into one 20-bit word.
//   clk, rst       - clock, asynchronous active-high reset
//   i_clear        - restart byte indexing at b0 (new load)
//   i_byte_fire    - a data byte is transferred this cycle
//   i_byte         - the transferred byte
//   o_word         - {b2[3:0], b1, b0}, valid while o_word_ready is high
//   o_word_ready   - pulse on the cycle the third byte is transferred
module word_assembler
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_fire,
  input  logic [7:0]  i_byte,
  output logic [19:0] o_word,
  output logic        o_word_ready
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [7:0] r_b0;
  logic [7:0] r_b1;
  logic [1:0] r_idx;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b0  <= '0;
      r_b1  <= '0;
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_byte_fire) begin
      case (r_idx)
        2'd0:    r_b0 <= i_byte;
        2'd1:    r_b1 <= i_byte;
        default: ;
      endcase
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 2'd1;
    end
  end

  // b2 is never stored: the word is formed in the cycle it arrives and the
  // top level registers it, so only its low nibble is used.
  assign o_word_ready = i_byte_fire && (r_idx == LAST_IDX);
  assign o_word       = {i_byte[3:0], r_b1, r_b0};

endmodule

// File: rtl/mem_loader.sv
// mem_loader: parses a 16-bit word-count header followed by 3-byte words and
// writes them to consecutive data-memory addresses starting at 0, holding the
// processor in reset until the load completes.
//   clk, rst                  - clock, asynchronous active-high reset
//   i_start                   - begin a load (honoured in IDLE and DONE only)
//   i_byte_in / i_byte_valid  - inbound byte stream
//   o_byte_ready              - byte accepted when high together with valid
//   o_mem_write/addr/wdata    - data-memory write port (one-cycle strobe)
//   o_cpu_rst                 - processor reset hold
//   o_done / o_error          - load finished / header count too large
//   o_word_count              - words written in the current load
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MEM_SIZE      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [7:0]               i_byte_in,
  input  logic                     i_byte_valid,
  output logic                     o_byte_ready,
  output logic                     o_mem_write,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  output logic                     o_cpu_rst,
  output logic                     o_done,
  output logic                     o_error,
  output logic [ADDRESS_WIDTH:0]   o_word_count
);

  localparam int CNT_W = ADDRESS_WIDTH + 1;

  loader_state_t            r_state;
  logic                     r_byte_ready;
  logic                     r_mem_write;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic                     r_cpu_rst;
  logic                     r_done;
  logic                     r_error;
  logic [CNT_W-1:0]         r_word_count;
  logic [LEN_WIDTH-1:0]     r_len;

  logic                     w_fire;
  logic                     w_begin;
  logic                     w_data_fire;
  logic [LEN_WIDTH-1:0]     w_len;
  logic [CNT_W-1:0]         w_count_next;
  logic                     w_more;
  logic [19:0]              w_word;
  logic                     w_word_ready;

  assign w_fire       = i_byte_valid && r_byte_ready;
  assign w_begin      = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_data_fire  = w_fire && (r_state == S_B0 || r_state == S_B1 || r_state == S_B2);
  assign w_len        = {i_byte_in, r_len[7:0]};
  assign w_count_next = r_word_count + CNT_W'(1);
  // Compared against the count after this write, so the address stops at
  // N-1 and never steps past the last word (255 for a full memory).
  assign w_more       = LEN_WIDTH'(w_count_next) < r_len;

  word_assembler u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_begin),
    .i_byte_fire  (w_data_fire),
    .i_byte       (i_byte_in),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  // byte_ready is registered alongside the state it belongs to, so it is
  // already low in the WRITE cycle and in DONE without depending on valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rst    <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_len        <= '0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state      <= S_LEN_LO;
            r_byte_ready <= 1'b1;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
            r_mem_addr   <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_fire) begin
            r_len[7:0] <= i_byte_in;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_fire) begin
            r_len <= w_len;
            if (w_len == '0 || w_len > LEN_WIDTH'(MEM_SIZE)) begin
              // Release the processor even on error: it runs with no data.
              r_error      <= (w_len != '0);
              r_state      <= S_DONE;
              r_byte_ready <= 1'b0;
              r_done       <= 1'b1;
              r_cpu_rst    <= 1'b0;
            end else begin
              r_state <= S_B0;
            end
          end
        end
        S_B0: if (w_fire) r_state <= S_B1;
        S_B1: if (w_fire) r_state <= S_B2;
        S_B2: begin
          if (w_word_ready) begin
            r_mem_wdata  <= w_word;
            r_mem_write  <= 1'b1;
            r_byte_ready <= 1'b0;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_word_count <= w_count_next;
          if (w_more) begin
            r_mem_addr   <= r_mem_addr + ADDRESS_WIDTH'(1);
            r_byte_ready <= 1'b1;
            r_state      <= S_B0;
          end else begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_mem_write  = r_mem_write;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_cpu_rst    = r_cpu_rst;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed stimulus for mem_loader with a write scoreboard.
// The driver pushes each expected {addr, data} write into a queue; a monitor
// on the falling edge pops and compares whenever mem_write is high.
`timescale 1ns/1ps
module tb_mem_loader;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [7:0]  i_byte_in;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        o_mem_write;
  logic [7:0]  o_mem_addr;
  logic [19:0] o_mem_wdata;
  logic        o_cpu_rst;
  logic        o_done;
  logic        o_error;
  logic [8:0]  o_word_count;

  int tests_run = 0;
  int tests_failed = 0;
  logic [27:0] exp_q[$];

  mem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_byte_in    (i_byte_in),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_mem_write  (o_mem_write),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_cpu_rst    (o_cpu_rst),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every write strobe against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && o_mem_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {24'd0, o_mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        check("write_addr", {24'd0, o_mem_addr}, {24'd0, e[27:20]});
        check("write_data", {12'd0, o_mem_wdata}, {12'd0, e[19:0]});
        check("ready_low_in_write", {31'd0, o_byte_ready}, 32'd0);
      end
    end
  end

  task automatic expect_write(input logic [7:0] addr, input logic [19:0] data);
    exp_q.push_back({addr, data});
  endtask

  // All driver tasks enter and leave 1 ns after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    // NOTE: inputs are driven with blocking assignments away from the clock
    // edge, so the DUT sees them settled before it samples.
    i_byte_in    = b;
    i_byte_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_byte_ready) check("byte_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit rand_gaps);
    send_byte(b0, rand_gaps ? int'($urandom_range(0, 2)) : 0);
    send_byte(b1, rand_gaps ? int'($urandom_range(0, 2)) : 0);
    send_byte(b2, rand_gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", {31'd0, o_done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    i_start      = 1'b0;
    i_byte_in    = 8'h00;
    i_byte_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
    check("rst_byte_ready", {31'd0, o_byte_ready}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_error", {31'd0, o_error}, 32'd0);
    check("rst_mem_write", {31'd0, o_mem_write}, 32'd0);
    check("rst_mem_addr", {24'd0, o_mem_addr}, 32'd0);
    check("rst_mem_wdata", {12'd0, o_mem_wdata}, 32'd0);
    check("rst_word_count", {23'd0, o_word_count}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_byte_ready", {31'd0, o_byte_ready}, 32'd0);
    pulse_start();
    check("start_byte_ready", {31'd0, o_byte_ready}, 32'd1);
    check("start_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);

    // Single word: 01 00 34 12 0A -> addr 0, data 0xA1234
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    expect_write(8'd0, 20'hA1234);
    send_word(8'h34, 8'h12, 8'h0A, 1'b0);
    check("w1_ready_low_after_b2", {31'd0, o_byte_ready}, 32'd0);
    check("w1_write_strobe", {31'd0, o_mem_write}, 32'd1);
    wait_done(20);
    check("w1_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
    check("w1_word_count", {23'd0, o_word_count}, 32'd1);
    check("w1_error", {31'd0, o_error}, 32'd0);
    check("w1_ready_in_done", {31'd0, o_byte_ready}, 32'd0);
    check("w1_queue_empty", exp_q.size(), 32'd0);

    // Three words with random gaps on byte_valid
    pulse_start();
    check("restart_done_cleared", {31'd0, o_done}, 32'd0);
    check("restart_count_cleared", {23'd0, o_word_count}, 32'd0);
    check("restart_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
    send_byte(8'h03, 1);
    send_byte(8'h00, 2);
    expect_write(8'd0, 20'h12345);
    expect_write(8'd1, 20'hABCDE);
    expect_write(8'd2, 20'h00F0F);
    send_word(8'h45, 8'h23, 8'h01, 1'b1);
    send_word(8'hDE, 8'hBC, 8'h7A, 1'b1);
    send_word(8'h0F, 8'h0F, 8'h30, 1'b1);
    wait_done(20);
    check("w3_word_count", {23'd0, o_word_count}, 32'd3);
    check("w3_queue_empty", exp_q.size(), 32'd0);

    // Full memory, b2 = 0xFF everywhere: upper nibble masked to 0xF
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] lo;
      lo = 8'(i);
      expect_write(lo, {4'hF, ~lo, lo});
      send_word(lo, ~lo, 8'hFF, 1'b0);
    end
    wait_done(20);
    check("full_word_count", {23'd0, o_word_count}, 32'd256);
    check("full_last_addr", {24'd0, o_mem_addr}, 32'd255);
    check("full_last_data", {12'd0, o_mem_wdata}, 32'hF00FF);
    check("full_queue_empty", exp_q.size(), 32'd0);

    // Header N = 0
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_done(5);
    check("n0_error", {31'd0, o_error}, 32'd0);
    check("n0_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
    check("n0_word_count", {23'd0, o_word_count}, 32'd0);

    // Header N = 257
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    wait_done(5);
    check("n257_error", {31'd0, o_error}, 32'd1);
    check("n257_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
    check("n257_word_count", {23'd0, o_word_count}, 32'd0);
    check("n257_ready", {31'd0, o_byte_ready}, 32'd0);

    // Reset after two of four words
    pulse_start();
    check("n257_error_cleared", {31'd0, o_error}, 32'd0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    expect_write(8'd0, 20'h56677);
    expect_write(8'd1, 20'h98899);
    send_word(8'h77, 8'h66, 8'h45, 1'b0);
    send_word(8'h99, 8'h88, 8'h09, 1'b0);
    @(posedge clk);
    #1;
    check("mid_two_writes_seen", exp_q.size(), 32'd0);
    check("mid_word_count", {23'd0, o_word_count}, 32'd2);
    send_byte(8'h55, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
    check("mid_rst_ready", {31'd0, o_byte_ready}, 32'd0);
    check("mid_rst_addr", {24'd0, o_mem_addr}, 32'd0);
    check("mid_rst_count", {23'd0, o_word_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle_ready", {31'd0, o_byte_ready}, 32'd0);

    // Reload from address 0; start pulses while busy must be ignored
    pulse_start();
    send_byte(8'h01, 0);
    pulse_start();
    send_byte(8'h00, 0);
    expect_write(8'd0, 20'h32211);
    send_byte(8'h11, 0);
    pulse_start();
    send_byte(8'h22, 0);
    send_byte(8'h93, 0);
    wait_done(20);
    check("reload_word_count", {23'd0, o_word_count}, 32'd1);
    check("reload_addr", {24'd0, o_mem_addr}, 32'd0);
    check("reload_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
    check("reload_queue_empty", exp_q.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Byte-stream memory loader that fills the pipeline's data memory before execution. It sits between a host byte source (testbench driver or UART receiver) and the data-memory write port. It is the inbound counterpart of the end-of-run memory dump. It parses a length header, assembles 20-bit words from byte triplets, writes them to consecutive addresses from 0, and holds the processor in reset until loading completes.

## Interface
- DATA_WIDTH, 20, memory word width; fixed at 20 for the 3-byte format
- ADDRESS_WIDTH, 8, memory address width
- MEM_SIZE, 256, number of memory words; maximum legal word count
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE, ignored elsewhere
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both high
- mem_write  out  1  one-cycle data-memory write strobe
- mem_addr  out  ADDRESS_WIDTH  write address
- mem_wdata  out  DATA_WIDTH  write data
- cpu_rst  out  1  processor reset hold
- done  out  1  load finished, level
- error  out  1  header count exceeded MEM_SIZE, level
- word_count  out  ADDRESS_WIDTH+1  words written in the current load

## Operation
- The stream format is as follows:
  - LEN_LO and LEN_HI bytes form N = {LEN_HI, LEN_LO}, a 16-bit count.
  - N data words follow, 3 bytes each, lowest byte first.
- Word assembly: mem_wdata = {b2[3:0], b1, b0}. The loader ignores b2[7:4].
- FSM states are IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE and DONE.
  - IDLE: start goes to LEN_LO.
  - LEN_LO: a transfer goes to LEN_HI.
  - LEN_HI: on a transfer, the next state depends on N:
    - N = 0 goes to DONE.
    - N > MEM_SIZE sets error and goes to DONE.
    - Otherwise the next state is B0.
  - B0 and B1: a transfer goes to B1 and B2 respectively.
  - B2: a transfer goes to WRITE.
  - WRITE: the next state is B0 if words remain, otherwise DONE.
  - DONE: start clears done, error and word_count, then goes to LEN_LO.
- byte_ready is high only in LEN_LO, LEN_HI, B0, B1 and B2. It is a registered function of state only and does not depend on byte_valid.
- mem_addr starts at 0 and increments after each WRITE. It never wraps within a load, because N is at most MEM_SIZE. N = 256 ends at address 255, and the address counter does not increment past it.
- word_count increments in WRITE and saturates at N.
- The loader accepts no bytes outside the header and data states; stray bytes are simply not acknowledged.

## Timing
- Reset values:
  - state IDLE
  - byte_ready 0
  - mem_write 0
  - mem_addr 0
  - mem_wdata 0
  - cpu_rst 1
  - done 0
  - error 0
  - word_count 0
- Throughput: at most one byte per cycle. One word takes 4 cycles minimum: 3 transfers plus 1 WRITE cycle with byte_ready low.
- mem_write is high for exactly the WRITE cycle. mem_addr and mem_wdata are stable during that cycle.
- Latency from the b2 transfer edge to mem_write high is 1 cycle.
- DONE entry behaviour:
  - done rises on the clock edge that enters DONE.
  - cpu_rst falls on that same edge, even when error is set, so the processor runs with partial or no data.
- cpu_rst rises again on the edge that leaves DONE via start.
- start while busy (LEN_LO through WRITE) is ignored and does not restart the load.
- rst mid-load returns the block to IDLE immediately, with all outputs at their reset values. The loader does not roll back memory words already written.
- If byte_valid drops in the middle of a word, the loader waits indefinitely with no timeout.

## Structure
- Package mem_loader_pkg holds:
  - the state enum loader_state_t
  - the byte-count constant BYTES_PER_WORD = 3
  - the header width LEN_WIDTH = 16
- Sub-module word_assembler holds the b0/b1 capture registers and a byte-index counter. It produces the assembled 20-bit word, plus a word_ready pulse on the third byte.
- The top-level mem_loader holds the FSM, the address counter, word_count, and the cpu_rst/done/error registers.

## Test plan
- Reset check: hold rst, release. Required: cpu_rst=1, byte_ready=0, done=0. After start, byte_ready=1 on the next cycle.
- Single-word load: stream 01 00 34 12 0A. Required: one mem_write with mem_addr=0 and mem_wdata=0xA1234. done=1, cpu_rst=0 and word_count=1 on the cycle after WRITE.
- Three-word load with back-pressure: N=3, with byte_valid toggled randomly. Required:
  - writes go to addresses 0, 1 and 2 in order with the correct data;
  - byte_ready is never high in WRITE;
  - no byte is lost or duplicated.
- Upper nibble masking and full memory: N=256, and every b2=0xFF. Required: the last write goes to address 255, all data upper nibbles are 0xF, and word_count=256.
- Header boundaries:
  - N=0: DONE is reached with no writes and error=0.
  - N=257: error=1 and no writes.
  - In both cases cpu_rst=0.
- Reset and restart: assert rst after 2 of 4 words have been written. Required: IDLE is entered immediately and cpu_rst=1. A new start then loads from address 0 again. A start pulse during a busy load causes no restart.
